// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI bus arbiter: FSM state encoding,
// word/index widths and a small helper for sizing counters.
package spi_pkg;

  localparam int SPI_WORD_W = 8;
  localparam int SLV_IDX_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: searches req from ptr+1 upward, wrapping,
// and returns the one-hot winner plus its index.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        gnt_o           = '0;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, then a
// full CS/SCLK byte transaction to the selected slave, returning the MISO byte.
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SLV  = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [SPI_WORD_W*NUM_REQ-1:0]  tx_data_i,
  input  logic [SLV_IDX_W*NUM_REQ-1:0]   slv_sel_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [SPI_WORD_W-1:0]          rx_data_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic                           sclk_o,
  output logic                           mosi_o,
  input  logic                           miso_i,
  output logic [NUM_SLV-1:0]             cs_n_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int PH_MAX = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_GAP));
  localparam int PH_W   = $clog2(PH_MAX + 1);

  spi_state_e               state_q;
  logic [IDX_W-1:0]         ptr_q;
  logic [PH_W-1:0]          phase_q;
  logic [2:0]               bit_q;
  logic [SPI_WORD_W-1:0]    tx_q;
  logic [SPI_WORD_W-1:0]    rx_q;
  logic [SPI_WORD_W-1:0]    rx_data_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [NUM_REQ-1:0]       ack_q;
  logic                     err_q;
  logic                     sclk_q;
  logic                     mosi_q;
  logic [NUM_SLV-1:0]       cs_n_q;

  logic [NUM_REQ-1:0]       win_gnt;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_valid;
  logic [SPI_WORD_W-1:0]    win_tx;
  logic [SLV_IDX_W-1:0]     win_sel;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    win_tx  = tx_data_i[win_idx*SPI_WORD_W +: SPI_WORD_W];
    win_sel = slv_sel_i[win_idx*SLV_IDX_W +: SLV_IDX_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      phase_q   <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) state_q <= ST_ARB;
        end

        ST_ARB: begin
          phase_q <= '0;
          bit_q   <= '0;
          if (!win_valid) begin
            state_q <= ST_IDLE;
          end else begin
            grant_q <= win_gnt;
            ptr_q   <= win_idx;
            tx_q    <= win_tx;
            // An out-of-range slave completes at once without touching the pins.
            if (int'(win_sel) >= NUM_SLV) begin
              err_q   <= 1'b1;
              ack_q   <= win_gnt;
              state_q <= ST_GAP;
            end else begin
              cs_n_q  <= ~(NUM_SLV'(1) << win_sel);
              mosi_q  <= win_tx[SPI_WORD_W-1];
              state_q <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          if (phase_q == PH_W'(CS_SETUP - 1)) begin
            phase_q <= '0;
            state_q <= ST_SHIFT;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (phase_q == PH_W'(CLK_DIV - 1)) begin
            phase_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[SPI_WORD_W-2:0], miso_i};
            end else begin
              // Falling edge: slave captures MOSI; present the next bit.
              sclk_q <= 1'b0;
              if (bit_q == 3'd7) begin
                state_q <= ST_HOLD;
              end else begin
                bit_q  <= bit_q + 3'd1;
                mosi_q <= tx_q[SPI_WORD_W-2];
                tx_q   <= {tx_q[SPI_WORD_W-2:0], 1'b0};
              end
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (phase_q == PH_W'(CS_HOLD - 1)) begin
            phase_q   <= '0;
            cs_n_q    <= '1;
            rx_data_q <= rx_q;
            ack_q     <= grant_q;
            grant_q   <= '0;
            state_q   <= ST_GAP;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        ST_GAP: begin
          grant_q <= '0;
          if (phase_q == PH_W'(CS_GAP - 1)) begin
            phase_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign ack_o     = ack_q;
  assign rx_data_o = rx_data_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign err_o     = err_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a default build plus a CLK_DIV=1 build,
// each with a simple byte-wide SPI slave model on its pins.
module tb_spi_bus_arbiter;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [3:0]  req_a;
  logic [31:0] tx_a;
  logic [11:0] sel_a;
  logic [3:0]  grant_a, ack_a;
  logic [7:0]  rx_a;
  logic        busy_a, err_a, sclk_a, mosi_a, miso_a;
  logic [1:0]  cs_a;

  spi_bus_arbiter #(
    .NUM_REQ(4), .NUM_SLV(2), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
  ) dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .tx_data_i(tx_a), .slv_sel_i(sel_a),
    .grant_o(grant_a), .ack_o(ack_a), .rx_data_o(rx_a), .busy_o(busy_a),
    .err_o(err_a), .sclk_o(sclk_a), .mosi_o(mosi_a), .miso_i(miso_a), .cs_n_o(cs_a)
  );

  // CLK_DIV=1 instance
  logic [3:0]  req_b;
  logic [31:0] tx_b;
  logic [11:0] sel_b;
  logic [3:0]  grant_b, ack_b;
  logic [7:0]  rx_b;
  logic        busy_b, err_b, sclk_b, mosi_b, miso_b;
  logic [1:0]  cs_b;

  spi_bus_arbiter #(
    .NUM_REQ(4), .NUM_SLV(2), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
  ) dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .tx_data_i(tx_b), .slv_sel_i(sel_b),
    .grant_o(grant_b), .ack_o(ack_b), .rx_data_o(rx_b), .busy_o(busy_b),
    .err_o(err_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .miso_i(miso_b), .cs_n_o(cs_b)
  );

  // Slave model A: shifts out slave_a MSB first, captures MOSI on SCLK falls,
  // and tracks CS-high gaps and SCLK level at CS edges.
  logic [7:0] slave_a, cap_a;
  int         rise_a, fall_a, run_a, min_gap_a, viol_a;
  logic       seen_a, sclk_pa, mosi_pa;
  logic [1:0] cs_pa;

  always @(negedge clk) begin
    if (rst) begin
      rise_a = 0; fall_a = 0; run_a = 0; min_gap_a = 1000; viol_a = 0;
      seen_a = 1'b0; cap_a = 8'h00;
    end else begin
      if ((cs_a != cs_pa) && (sclk_a || sclk_pa)) viol_a++;
      if (&cs_a) begin
        run_a++;
      end else begin
        if (&cs_pa) begin
          if (seen_a && run_a < min_gap_a) min_gap_a = run_a;
          seen_a = 1'b1; run_a = 0; rise_a = 0; fall_a = 0; cap_a = 8'h00;
        end
        if (sclk_a && !sclk_pa) rise_a++;
        if (!sclk_a && sclk_pa) begin
          cap_a = {cap_a[6:0], mosi_pa};
          fall_a++;
        end
      end
    end
    miso_a  = (rise_a < 8) ? slave_a[7-rise_a] : 1'b0;
    sclk_pa = sclk_a;
    mosi_pa = mosi_a;
    cs_pa   = cs_a;
  end

  // Slave model B
  logic [7:0] slave_b, cap_b;
  int         rise_b, fall_b, low_b;
  logic       sclk_pb, mosi_pb;
  logic [1:0] cs_pb;

  always @(negedge clk) begin
    if (rst) begin
      rise_b = 0; fall_b = 0; low_b = 0; cap_b = 8'h00;
    end else if (!(&cs_b)) begin
      if (&cs_pb) begin
        rise_b = 0; fall_b = 0; low_b = 0; cap_b = 8'h00;
      end
      low_b++;
      if (sclk_b && !sclk_pb) rise_b++;
      if (!sclk_b && sclk_pb) begin
        cap_b = {cap_b[6:0], mosi_pb};
        fall_b++;
      end
    end
    miso_b  = (rise_b < 8) ? slave_b[7-rise_b] : 1'b0;
    sclk_pb = sclk_b;
    mosi_pb = mosi_b;
    cs_pb   = cs_b;
  end

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int n;
    n = 0;
    while (busy_a && n < 300) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy_a}, 32'd0);
  endtask

  // Waits for the next grant, checks it, then checks the matching ack.
  task automatic rr_step(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    while (grant_a == 4'b0000 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, {28'd0, grant_a}, {28'd0, exp});
    n = 0;
    while (ack_a == 4'b0000 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_ack"}, {28'd0, ack_a}, {28'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    logic bad;

    rst     = 1'b1;
    req_a   = '0; tx_a = '0; sel_a = '0; slave_a = 8'h00;
    req_b   = '0; tx_b = '0; sel_b = '0; slave_b = 8'h00;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_cs_n",  {30'd0, cs_a},    32'h3);
    chk("rst_sclk",  {31'd0, sclk_a},  32'h0);
    chk("rst_mosi",  {31'd0, mosi_a},  32'h0);
    chk("rst_grant", {28'd0, grant_a}, 32'h0);
    chk("rst_ack",   {28'd0, ack_a},   32'h0);
    chk("rst_err",   {31'd0, err_a},   32'h0);
    chk("rst_busy",  {31'd0, busy_a},  32'h0);
    chk("rst_rx",    {24'd0, rx_a},    32'h0);

    // Single transfer: 0xA5 to slave 1, slave answers 0x3C
    slave_a     = 8'h3C;
    tx_a[7:0]   = 8'hA5;
    sel_a[2:0]  = 3'd1;
    req_a       = 4'b0001;
    tick();
    chk("t1_arb_busy",  {31'd0, busy_a},  32'h1);
    chk("t1_arb_grant", {28'd0, grant_a}, 32'h0);
    tick();
    lat = 1;
    bad = 1'b0;
    while (!ack_a[0] && lat < 300) begin
      if (cs_a !== 2'b01 || grant_a !== 4'b0001) bad = 1'b1;
      tick();
      lat++;
    end
    req_a = 4'b0000;
    chk("t1_latency",    lat,              32'd69);
    chk("t1_cs_grant",   {31'd0, bad},     32'h0);
    chk("t1_ack",        {28'd0, ack_a},   32'h1);
    chk("t1_rx_data",    {24'd0, rx_a},    32'h3C);
    chk("t1_mosi_bits",  {24'd0, cap_a},   32'hA5);
    chk("t1_falls",      fall_a,           32'd8);
    chk("t1_grant_drop", {28'd0, grant_a}, 32'h0);
    chk("t1_cs_release", {30'd0, cs_a},    32'h3);
    tick();
    chk("t1_ack_pulse",  {28'd0, ack_a},   32'h0);

    // Bad slave select from requester 2
    wait_idle_a("t4_idle");
    sel_a[8:6] = 3'd5;
    req_a      = 4'b0100;
    tick();
    chk("t4_arb_busy", {31'd0, busy_a}, 32'h1);
    tick();
    req_a = 4'b0000;
    chk("t4_err",     {31'd0, err_a},  32'h1);
    chk("t4_ack",     {28'd0, ack_a},  32'h4);
    chk("t4_cs_n",    {30'd0, cs_a},   32'h3);
    chk("t4_rx_keep", {24'd0, rx_a},   32'h3C);
    tick();
    chk("t4_err_pulse", {31'd0, err_a}, 32'h0);
    chk("t4_ack_pulse", {28'd0, ack_a}, 32'h0);
    wait_idle_a("t4_idle_end");
    chk("t4_cs_n_end", {30'd0, cs_a}, 32'h3);
    chk("t4_rx_end",   {24'd0, rx_a}, 32'h3C);

    // Round-robin with all four requesting
    do_reset();
    tx_a  = 32'h44_33_22_11;
    sel_a = {3'd1, 3'd0, 3'd1, 3'd0};
    req_a = 4'b1111;
    rr_step("rr0", 4'b0001);
    rr_step("rr1", 4'b0010);
    rr_step("rr2", 4'b0100);
    rr_step("rr3", 4'b1000);
    rr_step("rr4", 4'b0001);
    req_a = 4'b0000;
    tests++;
    assert (min_gap_a >= 5) else begin
      failed++;
      $error("FAIL cs_gap: observed %0d cycles required >= 5", min_gap_a);
    end
    chk("sclk_at_cs_edge", viol_a, 32'd0);
    wait_idle_a("rr_idle");

    // Pointer at 2, then only requesters 0 and 1
    do_reset();
    req_a = 4'b1111;
    rr_step("p0", 4'b0001);
    rr_step("p1", 4'b0010);
    rr_step("p2", 4'b0100);
    req_a = 4'b0011;
    rr_step("p3", 4'b0001);
    rr_step("p4", 4'b0010);
    req_a = 4'b0000;
    wait_idle_a("p_idle");

    // Asynchronous reset during bit 4 of a transfer
    do_reset();
    sel_a[5:3] = 3'd0;
    req_a      = 4'b0010;
    tick();
    repeat (37) tick();
    chk("t5_pre_grant", {28'd0, grant_a}, 32'h2);
    chk("t5_pre_cs",    {30'd0, cs_a},    32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_cs",    {30'd0, cs_a},    32'h3);
    chk("t5_async_sclk",  {31'd0, sclk_a},  32'h0);
    chk("t5_async_grant", {28'd0, grant_a}, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    req_a = 4'b1111;
    rr_step("t5_restart", 4'b0001);
    req_a = 4'b0000;
    wait_idle_a("t5_idle");

    // CLK_DIV=1 build: one transfer
    slave_b    = 8'h96;
    tx_b[7:0]  = 8'hC3;
    sel_b[2:0] = 3'd0;
    req_b      = 4'b0001;
    tick();
    chk("t6_arb_busy", {31'd0, busy_b}, 32'h1);
    lat = 0;
    while (!ack_b[0] && lat < 300) begin
      tick();
      lat++;
    end
    req_b = 4'b0000;
    chk("t6_latency",   lat,            32'd21);
    chk("t6_rx_data",   {24'd0, rx_b},  32'h96);
    chk("t6_mosi_bits", {24'd0, cap_b}, 32'hC3);
    chk("t6_cs_low",    low_b,          32'd20);
    chk("t6_falls",     fall_b,         32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI master datapath between NUM_REQ on-chip requesters and drives up to NUM_SLV byte-wide SPI slaves, each on its own active-low chip select.
- Performs round-robin arbitration and sequences a full 8-bit transaction for each grant: CS assert, setup, 8 SCLK periods, hold, CS deassert, gap.
- Returns the byte shifted in on MISO to the granted requester.
- Sits between the system-clocked logic and the slave pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_SLV, 2, number of chip-select lines (1..8)
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
- CS_SETUP, 2, clk cycles from CS low to the first SCLK rise window
- CS_HOLD, 2, clk cycles from the last SCLK fall to CS high
- CS_GAP, 4, minimum clk cycles CS stays high between transactions (slave resets on CS rise)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  per-requester request; hold high until ack
- tx_data  in  8*NUM_REQ  byte to send; requester r uses [8r+7:8r]
- slv_sel  in  3*NUM_REQ  target slave index; requester r uses [3r+2:3r]
- grant  out  NUM_REQ  one-hot; high for the whole transaction
- ack  out  NUM_REQ  one-cycle pulse to the granted requester at completion
- rx_data  out  8  received byte; valid in the ack cycle, held until the next ack
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse when a requested slv_sel >= NUM_SLV
- sclk  out  1  SPI clock; idles low
- mosi  out  1  master out, MSB first
- miso  in  1  master in
- cs_n  out  NUM_SLV  active-low chip selects; at most one low at a time

Behaviour:
- Reset values: sclk=0, mosi=0, cs_n=all 1, grant=0, ack=0, err=0, busy=0, rx_data=0, RR pointer=NUM_REQ-1. The reset is asynchronous, so pins are released immediately even mid-transaction.
- FSM states: IDLE, ARB, SETUP, SHIFT, HOLD, GAP.
- IDLE -> ARB when any req is high.
- ARB (1 cycle):
  - Choose the first requester with req high, searching from pointer+1 and wrapping modulo NUM_REQ.
  - Latch that requester's tx_data and slv_sel, set grant one-hot, and update the pointer to the winner.
  - If the latched slv_sel >= NUM_SLV: pulse err, pulse ack, leave rx_data unchanged, and go to GAP without lowering any CS.
  - Otherwise lower cs_n[slv_sel] and go to SETUP.
- SETUP: hold for CS_SETUP cycles; mosi = tx[7] is driven on entry.
- SHIFT: 8 bits, i = 0..7, each lasting 2*CLK_DIV cycles.
  - Low half: sclk=0 and mosi=tx[7-i], changed only at the start of the low half.
  - At the end of the low half, sclk rises and MISO is sampled: rx <= {rx[6:0], miso}.
  - High half lasts CLK_DIV cycles; sclk then falls, and the slave samples MOSI on that fall.
  - After bit 7's fall, go to HOLD with sclk low.
- HOLD: CS_HOLD cycles. Then raise all cs_n, copy rx to rx_data, pulse ack, drop grant, and go to GAP.
- GAP: CS_GAP cycles, then go to IDLE. Arbitration therefore never overlaps CS high time.
- Latency from the ARB cycle to ack = 1 + CS_SETUP + 16*CLK_DIV + CS_HOLD cycles. With defaults: 69.
- req deasserted mid-transaction: ignored; the transaction completes and ack still pulses.
- req changes after ARB: tx_data and slv_sel are latched in ARB, so later changes have no effect.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 transactions.
- Only one requester is ever granted.
- Counters: bit counter is 3 bits; phase counter is sized for max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP).

Decomposition:
- Package spi_pkg:
  - FSM state enum
  - SPI_WORD_W=8
  - SLV_IDX_W=3
- Sub-module spi_rr_arbiter: combinational round-robin pick from req plus pointer, producing a one-hot grant and the winner index.
- Shift/timing logic stays in the top module.

Test Plan:
- Single transfer, defaults:
  - Stimulus: req[0]=1, tx=0xA5, slv=1, and the slave model returns 0x3C.
  - Required: cs_n=2'b01 for the whole transaction; mosi bits 1,0,1,0,0,1,0,1 on successive SCLK falls; ack[0] 69 cycles after ARB; rx_data=0x3C.
- Round-robin:
  - Stimulus: req=4'b1111 held high.
  - Required: grants in order 0,1,2,3,0; with the pointer at 2, req=4'b0011 grants 0 then 1.
- Gap and reset compliance:
  - Stimulus: back-to-back requests.
  - Required: CS high for >= CS_GAP+1 cycles between transfers; sclk low whenever any cs_n transitions.
- Bad slave select:
  - Stimulus: slv_sel=5 with NUM_SLV=2.
  - Required: err and ack pulse one cycle after ARB; cs_n stays all 1; rx_data unchanged.
- Reset mid-shift:
  - Stimulus: assert rst during bit 4.
  - Required: cs_n=all 1, sclk=0, and grant=0 in the same cycle, asynchronously; the next request starts cleanly from requester 0.
- CLK_DIV=1 build:
  - Stimulus: one transfer.
  - Required: 16-cycle shift phase, correct data both ways, ack at cycle 1+2+16+2=21.
